// File: rtl/commit_trace_pkg.sv
// -----------------------------------------------------------------------------
// commit_trace_pkg
// Shared types for the commit trace buffer:
//   trace_entry_t : one buffered commit {pc, instr, rd, wdata}, ENTRY_W bits.
//   trace_state_t : capture sequencing states {IDLE, CAPTURE, DONE}.
// -----------------------------------------------------------------------------
package commit_trace_pkg;

    localparam int ENTRY_W = 101;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// First-word fall-through FIFO holding trace entries in registered storage.
// A push on a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is refused and the caller sees push_ok low.
//
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   push          : request to write push_data
//   push_data     : entry to write
//   pop           : consumer accepts head (ignored when empty)
//   head          : current head entry, zero when empty
//   valid         : FIFO not empty
//   full          : level == DEPTH
//   level         : occupancy, independent of pointer values
//   push_ok       : the push was accepted this cycle
//   pop_ok        : the head was consumed this cycle
// -----------------------------------------------------------------------------
module trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LVL_W   = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             valid,
    output logic             full,
    output logic [LVL_W-1:0] level,
    output logic             push_ok,
    output logic             pop_ok
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop && valid;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Masked so the output reads zero whenever nothing is buffered.
    assign head = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
// Samples the processor commit port every cycle and buffers register-writing
// commits (rd != x0) while capture is active. Entries drain to a debug host
// over a valid/ready port. A small FSM sequences IDLE -> CAPTURE -> DONE.
//
// Optional feature: define COMMIT_TRACE_DROP_CNT_EN to get a saturating count
// of dropped commits on drop_count; otherwise drop_count is tied to zero.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   in_pc, in_instr     : commit PC and instruction
//   in_reg_write, in_rd : commit writes register in_rd
//   in_wdata            : writeback data
//   start, stop         : capture control pulses (stop wins when both high)
//   limit               : entries to capture, 0 = unlimited
//   out_valid/out_ready : drain handshake, out_entry = {pc, instr, rd, wdata}
//   busy                : capture in progress
//   overflow            : sticky, a qualified commit was dropped
//   level               : FIFO occupancy
//   drop_count          : dropped-commit count (optional feature)
// -----------------------------------------------------------------------------
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_reg_write,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_wdata,
    input  logic                     start,
    input  logic                     stop,
    input  logic [CNT_W-1:0]         limit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_entry,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    trace_state_t state;
    logic [CNT_W-1:0] captured;
    logic [CNT_W-1:0] captured_inc;

    trace_entry_t commit_entry;
    trace_entry_t head_entry;
    logic         qualified;
    logic         fifo_full;
    logic         push_ok;
    logic         pop_ok;
    logic         drop;
    logic         start_accept;
    logic         limit_hit;

    assign commit_entry = '{pc: in_pc, instr: in_instr, rd: in_rd, wdata: in_wdata};

    // Writes to x0 have no architectural effect and are never traced.
    assign qualified    = (state == CAPTURE) && in_reg_write && (in_rd != 5'd0);
    assign drop         = qualified && !push_ok;
    assign start_accept = (state != CAPTURE) && start && !stop;
    assign captured_inc = captured + CNT_W'(1);
    assign limit_hit    = push_ok && (limit != '0) && (captured_inc == limit);

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (trace_entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (qualified),
        .push_data (commit_entry),
        .pop       (out_ready),
        .head      (head_entry),
        .valid     (out_valid),
        .full      (fifo_full),
        .level     (level),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok)
    );

    assign out_entry = head_entry;

    // Capture sequencing; busy is registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            captured <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_accept) begin
                        state    <= CAPTURE;
                        busy     <= 1'b1;
                        captured <= '0;
                        overflow <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (push_ok) begin
                        captured <= captured_inc;
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    if (stop || limit_hit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef COMMIT_TRACE_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= 16'h0000;
        end else if (start_accept) begin
            drop_cnt <= 16'h0000;
        end else if (drop) begin
            drop_cnt <= sat_inc16(drop_cnt);
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 16'h0000;
`endif

    // fifo_full is only observed through push_ok; kept for readability of the
    // instance and folded into a no-op here.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
